// File: rtl/csr_intr_unit_pkg.sv
// ----------------------------------------------------------------------------
// csr_intr_unit_pkg
// Shared definitions for the machine-mode CSR / interrupt unit and the
// control FSM: CSR addresses, mstatus bit positions, the mcause code loaded
// on external-interrupt entry, and the func3 CSR operation encoding.
// ----------------------------------------------------------------------------
package csr_intr_unit_pkg;

    localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    // Interrupt flag set, code 11 = machine external interrupt
    localparam logic [31:0] MCAUSE_M_EXT_IRQ = 32'h8000_000B;

    typedef enum logic [2:0] {
        CSR_OP_RW = 3'b001,
        CSR_OP_RS = 3'b010,
        CSR_OP_RC = 3'b011
    } csr_op_e;

    function automatic logic csr_op_valid(input logic [2:0] f3);
        return (f3 == CSR_OP_RW) || (f3 == CSR_OP_RS) || (f3 == CSR_OP_RC);
    endfunction

    // Read-modify-write result; an unknown op returns the current value
    function automatic logic [31:0] csr_op_apply(input logic [2:0]  f3,
                                                 input logic [31:0] cur,
                                                 input logic [31:0] opnd);
        logic [31:0] res;
        res = cur;
        case (f3)
            CSR_OP_RW: res = opnd;
            CSR_OP_RS: res = cur | opnd;
            CSR_OP_RC: res = cur & ~opnd;
            default:   res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// ----------------------------------------------------------------------------
// irq_sync
// Brings the asynchronous irq_in into the clk domain through SYNC_STAGES
// flops (legal range 2..4) and flags a synchronized 0->1 transition with one
// extra edge-detect flop.
//   clk      : system clock
//   RST_N    : synchronous active-low reset, clears every flop
//   irq_in   : asynchronous interrupt request
//   irq_rise : one-cycle pulse on a synchronized rising edge
// ----------------------------------------------------------------------------
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic RST_N,
    input  logic irq_in,
    output logic irq_rise
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   edge_p1;

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            sync_p0 <= '0;
            edge_p1 <= 1'b0;
        end else begin
            // stage p0: metastability chain, bit 0 samples the raw input
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], irq_in};
            // stage p1: previous synchronized level for edge detection
            edge_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign irq_rise = sync_p0[SYNC_STAGES-1] & ~edge_p1;

endmodule

// File: rtl/csr_intr_unit.sv
// ----------------------------------------------------------------------------
// csr_intr_unit
// Machine-mode CSR file (mstatus, mtvec, mepc, optional mcause) with a
// single rising-edge external interrupt source.
//
// Optional feature: define CSR_MCAUSE_EN to implement mcause (0x342).
// Without it there are no mcause flops, 0x342 reads 0 and writes are ignored.
//
// Ports
//   clk             : system clock, rising edge
//   RST_N           : synchronous active-low reset
//   irq_in          : asynchronous external interrupt request
//   pc              : PC saved into mepc on interrupt entry
//   csr_addr        : CSR address
//   func3           : CSR op (001 RW, 010 RS, 011 RC)
//   wd              : CSR write operand
//   csr_WE          : CSR write strobe
//   int_taken       : interrupt-entry strobe
//   mret_exec       : MRET strobe
//   intr            : pending interrupt to the control FSM
//   CSR_MSTATUS_MIE : mstatus.MIE
//   rd              : combinational read data at csr_addr
//   mtvec, mepc     : trap vector and exception PC registers
// ----------------------------------------------------------------------------
module csr_intr_unit
    import csr_intr_unit_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic        irq_in,
    input  logic [31:0] pc,
    input  logic [11:0] csr_addr,
    input  logic [2:0]  func3,
    input  logic [31:0] wd,
    input  logic        csr_WE,
    input  logic        int_taken,
    input  logic        mret_exec,
    output logic        intr,
    output logic        CSR_MSTATUS_MIE,
    output logic [31:0] rd,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);

    logic        irq_rise;
    logic        pending;
    logic        mie;
    logic        mpie;
    logic        csr_hit;
    logic        csr_wr;
    logic [31:0] csr_wval;
    logic        trap_entry;
`ifdef CSR_MCAUSE_EN
    logic [31:0] mcause;
`endif

    irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk      (clk),
        .RST_N    (RST_N),
        .irq_in   (irq_in),
        .irq_rise (irq_rise)
    );

    // MRET wins over a coincident interrupt entry
    assign trap_entry = int_taken & ~mret_exec;

    always_comb begin
        rd      = '0;
        csr_hit = 1'b0;
        case (csr_addr)
            CSR_ADDR_MSTATUS: begin
                rd[MSTATUS_MIE_BIT]  = mie;
                rd[MSTATUS_MPIE_BIT] = mpie;
                csr_hit              = 1'b1;
            end
            CSR_ADDR_MTVEC: begin
                rd      = mtvec;
                csr_hit = 1'b1;
            end
            CSR_ADDR_MEPC: begin
                rd      = mepc;
                csr_hit = 1'b1;
            end
`ifdef CSR_MCAUSE_EN
            CSR_ADDR_MCAUSE: begin
                rd      = mcause;
                csr_hit = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Trap entry / MRET own the cycle; a coincident software write is lost
    assign csr_wval = csr_op_apply(func3, rd, wd);
    assign csr_wr   = csr_WE & ~int_taken & ~mret_exec & csr_hit & csr_op_valid(func3);

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            mie  <= 1'b0;
            mpie <= 1'b0;
        end else if (mret_exec) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (int_taken) begin
            mpie <= mie;
            mie  <= 1'b0;
        end else if (csr_wr && csr_addr == CSR_ADDR_MSTATUS) begin
            mie  <= csr_wval[MSTATUS_MIE_BIT];
            mpie <= csr_wval[MSTATUS_MPIE_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            mtvec <= MTVEC_RST;
        end else if (csr_wr && csr_addr == CSR_ADDR_MTVEC) begin
            // direct mode only
            mtvec <= {csr_wval[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            mepc <= '0;
        end else if (trap_entry) begin
            mepc <= pc;
        end else if (csr_wr && csr_addr == CSR_ADDR_MEPC) begin
            mepc <= csr_wval;
        end
    end

`ifdef CSR_MCAUSE_EN
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            mcause <= '0;
        end else if (trap_entry) begin
            mcause <= MCAUSE_M_EXT_IRQ;
        end else if (csr_wr && csr_addr == CSR_ADDR_MCAUSE) begin
            mcause <= csr_wval;
        end
    end
`endif

    // A new edge arriving as the old request is acknowledged must not be lost
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            pending <= 1'b0;
        end else if (irq_rise) begin
            pending <= 1'b1;
        end else if (trap_entry) begin
            pending <= 1'b0;
        end
    end

    assign intr            = pending;
    assign CSR_MSTATUS_MIE = mie;

endmodule
